encoder_42: RTL and testbench
=============================

ENCODER_42 -- requirements
Module: encoder_42

Interface
REQ-001 HIZ_ON_INVALID, default 1: 1 drives y to high-impedance when the held result is invalid; 0 drives y to 2'b00 instead.
REQ-002 clk  input  1  clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 in_valid  input  1  qualifies i; a sample is taken only on a rising clk edge with in_valid=1.
REQ-005 i  input  4  encoder input; one-hot word expected.
REQ-006 y  output  2  encoded index of the set bit; tri-state capable.
REQ-007 y_valid  output  1  high while y holds a valid code.
REQ-008 err  output  1  one-cycle pulse after an invalid sample.
REQ-009 err_count  output  8  saturating count of invalid samples since reset.

Function
REQ-010 Encoding SHALL be: i=0001 -> 00, 0010 -> 01, 0100 -> 10, 1000 -> 11.
REQ-011 Without the Configuration macro, any i that is not exactly one-hot, including 0000, SHALL be invalid.
REQ-012 Latency SHALL be one cycle: a sample taken at edge N updates y, y_valid and err after edge N.
REQ-013 For a valid sample, the encoded value SHALL be registered, with y_valid=1 and err=0.
REQ-014 For an invalid sample, y_valid SHALL be 0, err SHALL be 1 for exactly one cycle, and err_count SHALL increment.
REQ-015 err_count SHALL saturate at 255 and never wrap.
REQ-016 When in_valid=0, the code register, y_valid and err_count SHALL hold, and err SHALL be 0.
REQ-017 When y_valid=0, y SHALL be 2'bzz if HIZ_ON_INVALID=1, else 2'b00.
REQ-018 When y_valid=1, y SHALL equal the registered code.
REQ-019 The registered code SHALL be left unchanged by invalid samples.

Reset
REQ-020 When rst=1 at a clk edge, the code register SHALL be cleared to 00, and y_valid, err and err_count SHALL be cleared to 0.
REQ-021 After reset, y SHALL be zz when HIZ_ON_INVALID=1, and 00 otherwise.
REQ-022 rst SHALL take precedence over a sample presented on the same edge.
REQ-023 A reset asserted mid-stream SHALL discard the pending result, so the result is not output.

Configuration
REQ-024 Macro ENCODER_42_PRIORITY_EN selects the encoding rule.
REQ-025 When ENCODER_42_PRIORITY_EN is defined, any nonzero i SHALL be valid and SHALL encode the index of its highest set bit; only 0000 is invalid.
REQ-026 When ENCODER_42_PRIORITY_EN is absent, strict one-hot checking per REQ-011 applies.

Structure
REQ-027 Package encoder_42_pkg SHALL hold the 2-bit code typedef and the four one-hot constants with their codes.
REQ-028 Sub-module encoder_42_core SHALL contain the purely combinational decode, with outputs code[1:0] and valid.
REQ-029 The top level SHALL contain the registers, the err/err_count logic and the tri-state output.

Verification
REQ-030 in_valid=1, i=0100 -> next cycle y=10, y_valid=1, err=0; i=0001 -> next cycle y=00.
REQ-031 Without the macro and HIZ_ON_INVALID=1, i=1001 -> next cycle y=zz, y_valid=0, err=1 for one cycle, err_count=1.
REQ-032 With ENCODER_42_PRIORITY_EN defined, i=1101 -> y=11, y_valid=1; i=0011 -> y=01; i=0000 -> y=zz, err=1.
REQ-033 Apply 300 consecutive samples of i=0000 -> err_count=255 and holds at 255.
REQ-034 Present i=0010, then rst=1 on the following edge -> y_valid=0, y=zz, err_count=0; with HIZ_ON_INVALID=0 -> y=00.
REQ-035 After i=1000 registers y=11, hold in_valid=0 with i=0001 -> y stays 11 and y_valid stays 1.

Source files
------------

// File: rtl/encoder_42_pkg.sv
// Shared types and constants for the 4-to-2 encoder.
// Build macro ENCODER_42_PRIORITY_EN switches the core to priority encoding.
package encoder_42_pkg;

   typedef logic [1:0] code_t;

   localparam logic [3:0] ONEHOT_0 = 4'b0001;
   localparam logic [3:0] ONEHOT_1 = 4'b0010;
   localparam logic [3:0] ONEHOT_2 = 4'b0100;
   localparam logic [3:0] ONEHOT_3 = 4'b1000;

   localparam code_t CODE_0 = 2'd0;
   localparam code_t CODE_1 = 2'd1;
   localparam code_t CODE_2 = 2'd2;
   localparam code_t CODE_3 = 2'd3;

   localparam logic [7:0] ERR_COUNT_MAX = 8'd255;

endpackage

// File: rtl/encoder_42_core.sv
// Combinational decode of the 4-bit input into a 2-bit code plus a validity flag.
// ENCODER_42_PRIORITY_EN: any nonzero input is valid and encodes its highest set bit.
module encoder_42_core
   import encoder_42_pkg::*;
(
   input  logic [3:0] i,
   output code_t      code,
   output logic       valid
);

   always_comb begin
      code  = CODE_0;
      valid = 1'b0;
`ifdef ENCODER_42_PRIORITY_EN
      if (i[3]) begin
         code  = CODE_3;
         valid = 1'b1;
      end else if (i[2]) begin
         code  = CODE_2;
         valid = 1'b1;
      end else if (i[1]) begin
         code  = CODE_1;
         valid = 1'b1;
      end else if (i[0]) begin
         code  = CODE_0;
         valid = 1'b1;
      end
`else
      case (i)
         ONEHOT_0: begin code = CODE_0; valid = 1'b1; end
         ONEHOT_1: begin code = CODE_1; valid = 1'b1; end
         ONEHOT_2: begin code = CODE_2; valid = 1'b1; end
         ONEHOT_3: begin code = CODE_3; valid = 1'b1; end
         default:  begin code = CODE_0; valid = 1'b0; end
      endcase
`endif
   end

endmodule

// File: rtl/encoder_42.sv
// Registered 4-to-2 encoder with error pulse, saturating error count and tri-state output.
// Build macro ENCODER_42_PRIORITY_EN selects priority encoding instead of strict one-hot.
module encoder_42
   import encoder_42_pkg::*;
#(
   parameter bit HIZ_ON_INVALID = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic [3:0] i,
   output tri logic [1:0] y,
   output logic       y_valid,
   output logic       err,
   output logic [7:0] err_count
);

   code_t      dec_code;
   logic       dec_valid;

   code_t      code_q, code_d;
   logic       y_valid_q, y_valid_d;
   logic       err_q, err_d;
   logic [7:0] err_count_q, err_count_d;

   encoder_42_core u_core (
      .i     (i),
      .code  (dec_code),
      .valid (dec_valid)
   );

   // Invalid samples keep the last good code; only the valid flag drops.
   always_comb begin
      code_d      = code_q;
      y_valid_d   = y_valid_q;
      err_d       = 1'b0;
      err_count_d = err_count_q;
      if (in_valid) begin
         if (dec_valid) begin
            code_d    = dec_code;
            y_valid_d = 1'b1;
         end else begin
            y_valid_d = 1'b0;
            err_d     = 1'b1;
            if (err_count_q != ERR_COUNT_MAX) begin
               err_count_d = err_count_q + 8'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         code_q      <= CODE_0;
         y_valid_q   <= 1'b0;
         err_q       <= 1'b0;
         err_count_q <= 8'd0;
      end else begin
         code_q      <= code_d;
         y_valid_q   <= y_valid_d;
         err_q       <= err_d;
         err_count_q <= err_count_d;
      end
   end

   assign y_valid   = y_valid_q;
   assign err       = err_q;
   assign err_count = err_count_q;

   generate
      if (HIZ_ON_INVALID) begin : g_hiz
         assign y = y_valid_q ? code_q : 2'bzz;
      end else begin : g_zero
         assign y = y_valid_q ? code_q : 2'b00;
      end
   endgenerate

endmodule

// File: tb/tb_encoder_42.sv
// Bench for encoder_42: randomized samples against a behavioural model plus literal checks.
// A released y is detected by pairing a pulled-up net with a pulled-down net.
module tb_encoder_42;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [3:0] i = 4'b0000;

   wire [1:0] y_pu, y_pd, y_nz;
   wire       y_valid, y_valid_pd, y_valid_nz;
   wire       err, err_pd, err_nz;
   wire [7:0] err_count, err_count_pd, err_count_nz;

   pullup   (y_pu[0]);
   pullup   (y_pu[1]);
   pulldown (y_pd[0]);
   pulldown (y_pd[1]);

   encoder_42 #(.HIZ_ON_INVALID(1'b1)) u_dut_pu (
      .clk(clk), .rst(rst), .in_valid(in_valid), .i(i),
      .y(y_pu), .y_valid(y_valid), .err(err), .err_count(err_count)
   );
   encoder_42 #(.HIZ_ON_INVALID(1'b1)) u_dut_pd (
      .clk(clk), .rst(rst), .in_valid(in_valid), .i(i),
      .y(y_pd), .y_valid(y_valid_pd), .err(err_pd), .err_count(err_count_pd)
   );
   encoder_42 #(.HIZ_ON_INVALID(1'b0)) u_dut_nz (
      .clk(clk), .rst(rst), .in_valid(in_valid), .i(i),
      .y(y_nz), .y_valid(y_valid_nz), .err(err_nz), .err_count(err_count_nz)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit check_en = 1'b0;

   // Behavioural model state
   int   m_code = 0;
   bit   m_valid = 1'b0;
   bit   m_err = 1'b0;
   int   m_cnt = 0;

   function automatic bit model_ok(input logic [3:0] x);
`ifdef ENCODER_42_PRIORITY_EN
      return x != 4'b0000;
`else
      return $countones(x) == 1;
`endif
   endfunction

   function automatic int model_idx(input logic [3:0] x);
      int idx = 0;
      for (int k = 0; k < 4; k++) if (x[k]) idx = k;
      return idx;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: drive on the falling edge, then advance the model past the rising edge.
   task automatic step(input bit r, input bit v, input logic [3:0] x);
      @(negedge clk);
      rst = r;
      in_valid = v;
      i = x;
      @(posedge clk);
      #1;
      if (r) begin
         m_code = 0; m_valid = 1'b0; m_err = 1'b0; m_cnt = 0;
      end else if (v) begin
         if (model_ok(x)) begin
            m_code = model_idx(x); m_valid = 1'b1; m_err = 1'b0;
         end else begin
            m_valid = 1'b0; m_err = 1'b1;
            if (m_cnt < 255) m_cnt++;
         end
      end else begin
         m_err = 1'b0;
      end
   endtask

   // Compare process: every falling edge once the model is initialised.
   always @(negedge clk) begin
      if (check_en) begin
         chk("y_valid", {31'd0, y_valid}, {31'd0, m_valid});
         chk("y_valid_nz", {31'd0, y_valid_nz}, {31'd0, m_valid});
         chk("err", {31'd0, err}, {31'd0, m_err});
         chk("err_count", {24'd0, err_count}, m_cnt);
         chk("y_pu", {30'd0, y_pu}, m_valid ? m_code : 3);
         chk("y_pd", {30'd0, y_pd}, m_valid ? m_code : 0);
         chk("y_nz", {30'd0, y_nz}, m_valid ? m_code : 0);
      end
   end

   initial begin
      step(1'b1, 1'b0, 4'b0000);
      check_en = 1'b1;
      step(1'b1, 1'b1, 4'b0100);
      chk("rst_y_valid", {31'd0, y_valid}, 0);
      chk("rst_err", {31'd0, err}, 0);
      chk("rst_err_count", {24'd0, err_count}, 0);
      chk("rst_y_pu_hiz", {30'd0, y_pu}, 2'b11);
      chk("rst_y_pd_hiz", {30'd0, y_pd}, 2'b00);
      chk("rst_y_nz", {30'd0, y_nz}, 2'b00);

      step(1'b0, 1'b1, 4'b0100);
      chk("enc_0100_y", {30'd0, y_pd}, 2'b10);
      chk("enc_0100_y_valid", {31'd0, y_valid}, 1);
      chk("enc_0100_err", {31'd0, err}, 0);
      step(1'b0, 1'b1, 4'b0001);
      chk("enc_0001_y", {30'd0, y_pu}, 2'b00);

`ifdef ENCODER_42_PRIORITY_EN
      step(1'b0, 1'b1, 4'b1101);
      chk("pri_1101_y", {30'd0, y_pd}, 2'b11);
      chk("pri_1101_y_valid", {31'd0, y_valid}, 1);
      step(1'b0, 1'b1, 4'b0011);
      chk("pri_0011_y", {30'd0, y_pu}, 2'b01);
      step(1'b0, 1'b1, 4'b0000);
      chk("pri_0000_y_pu", {30'd0, y_pu}, 2'b11);
      chk("pri_0000_y_pd", {30'd0, y_pd}, 2'b00);
      chk("pri_0000_err", {31'd0, err}, 1);
      chk("pri_0000_err_count", {24'd0, err_count}, 1);
`else
      step(1'b0, 1'b1, 4'b1001);
      chk("inv_1001_y_pu", {30'd0, y_pu}, 2'b11);
      chk("inv_1001_y_pd", {30'd0, y_pd}, 2'b00);
      chk("inv_1001_y_valid", {31'd0, y_valid}, 0);
      chk("inv_1001_err", {31'd0, err}, 1);
      chk("inv_1001_err_count", {24'd0, err_count}, 1);
`endif
      step(1'b0, 1'b0, 4'b1001);
      chk("err_one_cycle", {31'd0, err}, 0);

      step(1'b0, 1'b1, 4'b1000);
      for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 4'b0001);
      chk("hold_y", {30'd0, y_pd}, 2'b11);
      chk("hold_y_valid", {31'd0, y_valid}, 1);

      step(1'b0, 1'b1, 4'b0010);
      step(1'b1, 1'b1, 4'b0010);
      chk("mid_rst_y_valid", {31'd0, y_valid}, 0);
      chk("mid_rst_y_pu", {30'd0, y_pu}, 2'b11);
      chk("mid_rst_y_pd", {30'd0, y_pd}, 2'b00);
      chk("mid_rst_y_nz", {30'd0, y_nz}, 2'b00);
      chk("mid_rst_err_count", {24'd0, err_count}, 0);

      for (int k = 0; k < 400; k++) begin
         step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)));
      end

      step(1'b1, 1'b0, 4'b0000);
      for (int k = 0; k < 300; k++) step(1'b0, 1'b1, 4'b0000);
      chk("sat_err_count", {24'd0, err_count}, 255);
      for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 4'b0000);
      chk("sat_hold", {24'd0, err_count}, 255);
      step(1'b0, 1'b1, 4'b0100);
      chk("sat_after_valid", {24'd0, err_count}, 255);
      chk("sat_valid_y", {30'd0, y_pd}, 2'b10);

      @(negedge clk);
      check_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
